// File: rtl/canvas_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : canvas_write_ctrl
// Description : Turns brush stamp requests and full-canvas clears into a
//               stream of single-pixel writes for a pixel store.
// Revision    : 1.0 - initial release
// ============================================================================
module canvas_write_ctrl #(
    parameter int         CANVAS_DIM  = 128,
    parameter logic [2:0] ERASE_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       brush_valid,
    output logic       brush_ready,
    input  logic [7:0] brush_x,
    input  logic [7:0] brush_y,
    input  logic [2:0] brush_color,
    input  logic [1:0] brush_size,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic [7:0] wx,
    output logic [7:0] wy,
    output logic [2:0] newColor,
    output logic       we
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [8:0] C_DIM  = 9'(CANVAS_DIM);
    localparam logic [7:0] C_LAST = 8'(CANVAS_DIM - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_pending;
    logic              r_busy;
    logic              r_we;
    logic [7:0]        r_wx;
    logic [7:0]        r_wy;
    logic [2:0]        r_wcolor;
    logic [7:0]        r_x;
    logic [7:0]        r_y;
    logic [2:0]        r_color;
    logic [1:0]        r_rad;
    logic signed [3:0] r_dx;
    logic signed [3:0] r_dy;
    logic [7:0]        r_cx;
    logic [7:0]        r_cy;

    logic              w_ready;
    logic signed [3:0] w_rad;
    logic signed [3:0] w_neg_rad;
    logic signed [3:0] w_neg_size;
    logic [8:0]        w_sx;
    logic [8:0]        w_sy;
    logic              w_in_range;
    logic              w_stamp_last;
    logic              w_clear_last;
    logic              w_clear_due;

    assign w_rad      = $signed({2'b00, r_rad});
    assign w_neg_rad  = -w_rad;
    assign w_neg_size = -$signed({2'b00, brush_size});

    // Negative sums set bit 8, so one unsigned compare covers both bounds.
    assign w_sx       = {1'b0, r_x} + {{5{r_dx[3]}}, r_dx};
    assign w_sy       = {1'b0, r_y} + {{5{r_dy[3]}}, r_dy};
    assign w_in_range = (w_sx < C_DIM) && (w_sy < C_DIM);

    assign w_stamp_last = (r_dx == w_rad) && (r_dy == w_rad);
    assign w_clear_last = (r_cx == C_LAST) && (r_cy == C_LAST);
    assign w_clear_due  = clear_req || r_pending;

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !r_pending && !clear_req && !r_busy && !reset;
                if (w_clear_due) begin
                    w_next = CLEAR;
                end else if (brush_valid && w_ready) begin
                    w_next = STAMP;
                end
            end
            STAMP: begin
                if (w_stamp_last) begin
                    w_next = w_clear_due ? CLEAR : IDLE;
                end
            end
            CLEAR: begin
                if (w_clear_last) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == CLEAR) begin
                r_pending <= 1'b0;
            end else if (r_state == STAMP && clear_req) begin
                r_pending <= 1'b1;
            end
            // Busy covers the cycle that presents the last clear write.
            r_busy <= (w_next == CLEAR) || (r_state == CLEAR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_wx     <= 8'd0;
            r_wy     <= 8'd0;
            r_wcolor <= 3'd0;
            r_x      <= 8'd0;
            r_y      <= 8'd0;
            r_color  <= 3'd0;
            r_rad    <= 2'd0;
            r_dx     <= 4'sd0;
            r_dy     <= 4'sd0;
            r_cx     <= 8'd0;
            r_cy     <= 8'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                STAMP: begin
                    r_we     <= w_in_range;
                    r_wx     <= w_sx[7:0];
                    r_wy     <= w_sy[7:0];
                    r_wcolor <= r_color;
                    if (r_dx == w_rad) begin
                        r_dx <= w_neg_rad;
                        r_dy <= r_dy + 4'sd1;
                    end else begin
                        r_dx <= r_dx + 4'sd1;
                    end
                end
                CLEAR: begin
                    r_we     <= 1'b1;
                    r_wx     <= r_cx;
                    r_wy     <= r_cy;
                    r_wcolor <= ERASE_COLOR;
                    if (r_cx == C_LAST) begin
                        r_cx <= 8'd0;
                        r_cy <= r_cy + 8'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                default: begin
                    if (r_state == IDLE && w_next == STAMP) begin
                        r_x     <= brush_x;
                        r_y     <= brush_y;
                        r_color <= brush_color;
                        r_rad   <= brush_size;
                        r_dx    <= w_neg_size;
                        r_dy    <= w_neg_size;
                    end
                end
            endcase
            if (r_state != CLEAR && w_next == CLEAR) begin
                r_cx <= 8'd0;
                r_cy <= 8'd0;
            end
        end
    end

    assign brush_ready = w_ready;
    assign clear_busy  = r_busy;
    assign we          = r_we;
    assign wx          = r_wx;
    assign wy          = r_wy;
    assign newColor    = r_wcolor;

endmodule
`default_nettype wire
